// File: rtl/pu_riscv_ram_1r1w_fifo_ctrl_if.sv
// Push/pop stream plus the 1R1W RAM port of the FIFO controller.
// slave = controller view, master = producer/consumer/RAM view.
interface pu_riscv_ram_1r1w_fifo_ctrl_if #(
  parameter int ABITS = 16,
  parameter int DBITS = 32
);
  localparam int BBITS = (DBITS + 7) / 8;

  logic             wr_valid_i;
  logic [DBITS-1:0] wr_data_i;
  logic             wr_ready_o;
  logic             rd_valid_o;
  logic [DBITS-1:0] rd_data_o;
  logic             rd_ready_i;
  logic [ABITS-1:0] ram_waddr_o;
  logic [DBITS-1:0] ram_din_o;
  logic             ram_we_o;
  logic [BBITS-1:0] ram_be_o;
  logic [ABITS-1:0] ram_raddr_o;
  logic             ram_re_o;
  logic [DBITS-1:0] ram_dout_i;

  modport slave (
    input  wr_valid_i, wr_data_i, rd_ready_i, ram_dout_i,
    output wr_ready_o, rd_valid_o, rd_data_o,
    output ram_waddr_o, ram_din_o, ram_we_o, ram_be_o, ram_raddr_o, ram_re_o
  );

  modport master (
    output wr_valid_i, wr_data_i, rd_ready_i, ram_dout_i,
    input  wr_ready_o, rd_valid_o, rd_data_o,
    input  ram_waddr_o, ram_din_o, ram_we_o, ram_be_o, ram_raddr_o, ram_re_o
  );
endinterface

// File: rtl/pu_riscv_ram_1r1w_fifo_ctrl.sv
// FIFO controller on a 1R1W RAM with 1-cycle read latency; a 2-entry
// prefetch buffer in front of the read port sustains one pop per cycle.
module pu_riscv_ram_1r1w_fifo_ctrl #(
  parameter int ABITS = 16,
  parameter int DBITS = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  pu_riscv_ram_1r1w_fifo_ctrl_if.slave        bus,
  output logic [ABITS:0]                      count_o,
  output logic                                empty_o,
  output logic                                full_o
);
  localparam int BBITS = (DBITS + 7) / 8;
  localparam logic [ABITS:0] RAM_DEPTH = {1'b1, {ABITS{1'b0}}};
  localparam logic [ABITS:0] CNT_ONE   = {{ABITS{1'b0}}, 1'b1};
  localparam logic [ABITS-1:0] PTR_ONE = {{(ABITS-1){1'b0}}, 1'b1};

  typedef enum logic {
    RD_IDLE,
    RD_PEND
  } rd_state_e;

  rd_state_e        rd_state_q, rd_state_d;
  logic [ABITS-1:0] wptr_q, wptr_d;
  logic [ABITS-1:0] rptr_q, rptr_d;
  logic [ABITS:0]   ram_cnt_q, ram_cnt_d;
  logic [1:0]       obuf_cnt_q, obuf_cnt_d;
  logic [DBITS-1:0] obuf_q [2];
  logic [DBITS-1:0] obuf_d [2];
  logic [ABITS:0]   count_q, count_d;

  logic       wr_ready;
  logic       push;
  logic       rd_valid;
  logic       pop;
  logic       re;
  logic       capture;
  logic [2:0] occ;

  // Handshakes; everything is held off while reset is asserted.
  assign wr_ready = ~rst_i & (ram_cnt_q != RAM_DEPTH);
  assign push     = bus.wr_valid_i & wr_ready;
  assign rd_valid = ~rst_i & (obuf_cnt_q != 2'd0);
  assign pop      = rd_valid & bus.rd_ready_i;
  assign capture  = (rd_state_q == RD_PEND);

  // Slots already claimed in the output buffer, counting the read in flight.
  assign occ = {1'b0, obuf_cnt_q} + {2'b00, capture};
  assign re  = ~rst_i & (ram_cnt_q != '0) & (occ < (3'd2 + {2'b00, pop}));

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE: if (re) rd_state_d = RD_PEND;
      RD_PEND: rd_state_d = re ? RD_PEND : RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    wptr_d    = push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d    = re   ? rptr_q + PTR_ONE : rptr_q;
    ram_cnt_d = ram_cnt_q;
    case ({push, re})
      2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
      2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
      default: ram_cnt_d = ram_cnt_q;
    endcase
  end

  // Output buffer: slot 0 is always the head, so a pop shifts slot 1 down
  // and a capture lands in the first slot left free after that shift.
  always_comb begin
    obuf_d[0]  = obuf_q[0];
    obuf_d[1]  = obuf_q[1];
    obuf_cnt_d = obuf_cnt_q;
    if (pop) begin
      obuf_d[0] = obuf_q[1];
    end
    if (capture) begin
      if ((obuf_cnt_q == 2'd0) || ((obuf_cnt_q == 2'd1) && pop)) begin
        obuf_d[0] = bus.ram_dout_i;
      end else begin
        obuf_d[1] = bus.ram_dout_i;
      end
    end
    case ({pop, capture})
      2'b10:   obuf_cnt_d = obuf_cnt_q - 2'd1;
      2'b01:   obuf_cnt_d = obuf_cnt_q + 2'd1;
      default: obuf_cnt_d = obuf_cnt_q;
    endcase
  end

  always_comb begin
    count_d = ram_cnt_d
            + {{ABITS{1'b0}}, (rd_state_d == RD_PEND)}
            + {{(ABITS-1){1'b0}}, obuf_cnt_d};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= RD_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      obuf_cnt_q <= '0;
      count_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        obuf_q[i] <= '0;
      end
    end else begin
      rd_state_q <= rd_state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      obuf_cnt_q <= obuf_cnt_d;
      count_q    <= count_d;
      for (int i = 0; i < 2; i++) begin
        obuf_q[i] <= obuf_d[i];
      end
    end
  end

  assign bus.wr_ready_o  = wr_ready;
  assign bus.rd_valid_o  = rd_valid;
  assign bus.rd_data_o   = rst_i ? '0 : obuf_q[0];
  assign bus.ram_waddr_o = wptr_q;
  assign bus.ram_din_o   = bus.wr_data_i;
  assign bus.ram_we_o    = push;
  assign bus.ram_be_o    = {BBITS{1'b1}};
  assign bus.ram_raddr_o = rptr_q;
  assign bus.ram_re_o    = re;

  assign count_o = rst_i ? '0 : count_q;
  assign empty_o = (count_o == '0);
  assign full_o  = ~wr_ready;
endmodule

// File: tb/tb_pu_riscv_ram_1r1w_fifo_ctrl.sv
// Directed bench for the FIFO controller with a behavioural 1R1W RAM
// (registered read) and a scoreboard of accepted pushes.
module tb_pu_riscv_ram_1r1w_fifo_ctrl;
  localparam int ABITS = 2;
  localparam int DBITS = 32;
  localparam int DEPTH = 1 << ABITS;

  logic             clk;
  logic             rst;
  logic [ABITS:0]   count;
  logic             empty;
  logic             full;

  int checks   = 0;
  int failures = 0;
  int pop_cnt  = 0;
  int exp_wptr = 0;
  int exp_rptr = 0;
  logic [DBITS-1:0] sb [$];
  logic [DBITS-1:0] mem [DEPTH];

  pu_riscv_ram_1r1w_fifo_ctrl_if #(.ABITS(ABITS), .DBITS(DBITS)) bus ();

  pu_riscv_ram_1r1w_fifo_ctrl #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage model: write on we, registered read on re.
  always @(posedge clk) begin
    if (bus.ram_we_o) mem[bus.ram_waddr_o] <= bus.ram_din_o;
    if (bus.ram_re_o) bus.ram_dout_i <= mem[bus.ram_raddr_o];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at negedge+1 with this cycle's inputs applied; records the
  // cycle's handshakes and ends at the next negedge.
  task automatic tick();
    logic [DBITS-1:0] exp_data;
    if (bus.wr_valid_i && bus.wr_ready_o) begin
      check_eq("ram_we", bus.ram_we_o, 1);
      check_eq("ram_din", bus.ram_din_o, bus.wr_data_i);
      check_eq("waddr", bus.ram_waddr_o, exp_wptr);
      exp_wptr = (exp_wptr + 1) % DEPTH;
      sb.push_back(bus.wr_data_i);
    end else begin
      check_eq("ram_we_idle", bus.ram_we_o, 0);
    end
    if (bus.ram_re_o) begin
      check_eq("raddr", bus.ram_raddr_o, exp_rptr);
      exp_rptr = (exp_rptr + 1) % DEPTH;
    end
    if (bus.rd_valid_o && bus.rd_ready_i) begin
      check_eq("pop_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        exp_data = sb.pop_front();
        check_eq("pop_data", bus.rd_data_o, exp_data);
      end
      pop_cnt++;
      $display("pop data=0x%08h", bus.rd_data_o);
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("count", count, sb.size());
    check_eq("empty", empty, sb.size() == 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.wr_valid_i = 1'b1;
    bus.rd_ready_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      check_eq("rst_wr_ready", bus.wr_ready_o, 0);
      check_eq("rst_ram_we", bus.ram_we_o, 0);
      check_eq("rst_ram_re", bus.ram_re_o, 0);
      check_eq("rst_rd_valid", bus.rd_valid_o, 0);
      check_eq("rst_rd_data", bus.rd_data_o, 0);
      check_eq("rst_count", count, 0);
      @(posedge clk);
      @(negedge clk);
    end
    sb.delete();
    exp_wptr = 0;
    exp_rptr = 0;
    rst = 1'b0;
    bus.wr_valid_i = 1'b0;
  endtask

  initial begin
    int acc;
    int idx;
    int base;
    rst = 1'b1;
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = '0;
    bus.rd_ready_i = 1'b0;
    @(negedge clk);

    // 1. reset with wr_valid held high
    do_reset(2);
    #1;
    check_eq("ram_be", bus.ram_be_o, 4'hF);
    check_eq("post_rst_count", count, 0);
    check_eq("post_rst_valid", bus.rd_valid_o, 0);
    tick();

    // 2. single push, latency
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 32'hDEADBEEF;
    bus.rd_ready_i = 1'b1;
    #1;
    check_eq("t2_wr_ready", bus.wr_ready_o, 1);
    check_eq("t2_re_c0", bus.ram_re_o, 0);
    tick();
    bus.wr_valid_i = 1'b0;
    #1;
    check_eq("t2_re_c1", bus.ram_re_o, 1);
    check_eq("t2_raddr_c1", bus.ram_raddr_o, 0);
    check_eq("t2_valid_c1", bus.rd_valid_o, 0);
    tick();
    #1;
    check_eq("t2_re_c2", bus.ram_re_o, 0);
    check_eq("t2_valid_c2", bus.rd_valid_o, 0);
    tick();
    #1;
    check_eq("t2_valid_c3", bus.rd_valid_o, 1);
    check_eq("t2_data_c3", bus.rd_data_o, 32'hDEADBEEF);
    tick();
    #1;
    check_eq("t2_valid_c4", bus.rd_valid_o, 0);
    check_eq("t2_empty_c4", empty, 1);
    tick();

    // 3. fill with pops blocked, then push+pop at full, then drain
    acc = 0;
    bus.rd_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = i;
      #1;
      if (bus.wr_ready_o) acc++;
      tick();
    end
    bus.wr_valid_i = 1'b0;
    #1;
    check_eq("t3_accepted", acc, 6);
    check_eq("t3_full", full, 1);
    check_eq("t3_count", count, 6);
    tick();
    idx = 0;
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 32'h8;
    bus.rd_ready_i = 1'b1;
    #1;
    check_eq("t3_full_pop_wr_ready", bus.wr_ready_o, 0);
    check_eq("t3_order", bus.rd_data_o, idx);
    idx++;
    tick();
    bus.wr_valid_i = 1'b0;
    #1;
    check_eq("t3_wr_ready_next", bus.wr_ready_o, 1);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) #1;
      if (bus.rd_valid_o) begin
        check_eq("t3_order", bus.rd_data_o, idx);
        idx++;
      end
      tick();
    end
    check_eq("t3_pops", idx, 6);

    // 4. streaming: one push and one pop per cycle
    base = pop_cnt;
    bus.rd_ready_i = 1'b1;
    for (int c = 0; c < 26; c++) begin
      bus.wr_valid_i = (c < 20);
      bus.wr_data_i  = $urandom;
      #1;
      if (c >= 3 && c <= 22) check_eq("t4_stream_valid", bus.rd_valid_o, 1);
      if (c < 20) check_eq("t4_wr_ready", bus.wr_ready_o, 1);
      tick();
    end
    check_eq("t4_pops", pop_cnt - base, 20);

    // 5. three fill/drain rounds to wrap both pointers
    for (int r = 0; r < 3; r++) begin
      bus.rd_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i  = 32'h100 * (r + 1) + i;
        #1;
        tick();
      end
      bus.wr_valid_i = 1'b0;
      #1;
      check_eq("t5_fill_count", count, 6);
      tick();
      bus.rd_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
        #1;
        tick();
      end
      check_eq("t5_drained", count, 0);
    end

    // 6. reset while holding 4 entries with a read in flight
    bus.rd_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = 32'hA0 + i;
      #1;
      tick();
    end
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 32'hA4;
    bus.rd_ready_i = 1'b1;
    #1;
    check_eq("t6_re_issue", bus.ram_re_o, 1);
    tick();
    check_eq("t6_count_before", count, 4);
    bus.wr_valid_i = 1'b0;
    bus.rd_ready_i = 1'b0;
    do_reset(1);
    #1;
    check_eq("t6_count_after", count, 0);
    check_eq("t6_valid_after", bus.rd_valid_o, 0);
    tick();
    base = pop_cnt;
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 32'h1;
    bus.rd_ready_i = 1'b1;
    #1;
    tick();
    bus.wr_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      tick();
    end
    check_eq("t6_single_pop", pop_cnt - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
